// File: rtl/uart_rx_capture.sv
// uart_rx_capture: oversampling 8N1 UART receiver with glitch rejection,
// stop-bit framing check and a first-word-fall-through byte FIFO.
module uart_rx_capture #(
  parameter int FifoDepth = 8,
  parameter int CntWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [CntWidth-1:0] baud_div_i,
  input  logic                uart_rx_i,
  output logic [7:0]          data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                frame_err_o,
  output logic                overflow_o,
  output logic [CntWidth-1:0] drop_cnt_o,
  output logic                busy_o
);

  localparam int AddrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic                rx_s;
  logic [CntWidth-1:0] div_q, div_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] div_eff;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                expire;
  logic                push_req;
  logic                frame_err_d;

  logic [7:0]          mem_q [FifoDepth];
  logic [AddrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]      count_q;
  logic                full;
  logic                pop;
  logic                push_ok;
  logic                overflow_d;
  logic                frame_err_q;
  logic                overflow_q;
  logic [CntWidth-1:0] drop_cnt_q;

  assign rx_s    = sync_q[1];
  assign div_eff = (baud_div_i < CntWidth'(4)) ? CntWidth'(4) : baud_div_i;
  assign expire  = (cnt_q == CntWidth'(1));

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  // Receiver state, bit timing and shift register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      div_q     <= CntWidth'(4);
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Frame decoding: next state, sample points, push and framing-error requests
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_i && !rx_s) begin
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
          state_d = START;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            cnt_d     = div_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      DATA: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      STOP: begin
        if (expire) begin
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!en_i) begin
      state_d     = IDLE;
      push_req    = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  // A pop in the same cycle frees a slot in a full FIFO, so the push still lands
  assign full       = (count_q == (AddrW + 1)'(FifoDepth));
  assign valid_o    = (count_q != '0);
  assign pop        = valid_o && ready_i;
  assign push_ok    = push_req && (!full || pop);
  assign overflow_d = push_req && full && !pop;

  // FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Error pulses and the saturating drop counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      if (overflow_d && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CntWidth'(1);
      end
    end
  end

  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: scoreboard bench for uart_rx_capture; expected bytes
// are queued when a good frame is driven and checked as the FIFO delivers.
module tb_uart_rx_capture;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic [15:0] baudDiv;
  logic        rxLine;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        frameErr;
  logic        overflow;
  logic [15:0] dropCnt;
  logic        busy;

  int compared;
  int mismatched;
  int xferCount;
  int spuriousCount;
  int frameErrCount;
  int overflowCount;

  logic [7:0] sbQueue [$];

  uart_rx_capture #(
    .FifoDepth(8),
    .CntWidth (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .en_i       (enable),
    .baud_div_i (baudDiv),
    .uart_rx_i  (rxLine),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(frameErr),
    .overflow_o (overflow),
    .drop_cnt_o (dropCnt),
    .busy_o     (busy)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor on the falling edge: scoreboard pops and pulse counting
  always @(negedge clk) begin
    if (rstN) begin
      if (frameErr) frameErrCount++;
      if (overflow) overflowCount++;
      if (valid && ready) begin
        xferCount++;
        if (sbQueue.size() == 0) begin
          spuriousCount++;
        end else begin
          checkOutput("data_o", {24'h0, data}, {24'h0, sbQueue.pop_front()});
        end
      end
    end
  end

  // Advance one cycle and land just after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive frame bits [first..last] of {stop, data, start}, div cycles each
  task automatic applyBits(input logic [7:0] b, input int first, input int last, input int div);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = first; i <= last; i++) begin
      rxLine = frame[i];
      tick(div);
    end
  endtask

  // Send one full frame; stopLow > 0 holds the stop bit low that many cycles
  task automatic applyStimulus(input logic [7:0] b, input int div, input int stopLow, input bit expectGood);
    if (expectGood) sbQueue.push_back(b);
    applyBits(b, 0, 8, div);
    if (stopLow > 0) begin
      rxLine = 1'b0;
      tick(stopLow);
    end
    rxLine = 1'b1;
    tick(div);
  endtask

  int xferBefore;
  int errBefore;

  initial begin
    compared      = 0;
    mismatched    = 0;
    xferCount     = 0;
    spuriousCount = 0;
    frameErrCount = 0;
    overflowCount = 0;
    rstN    = 1'b0;
    enable  = 1'b1;
    baudDiv = 16'd16;
    rxLine  = 1'b1;
    ready   = 1'b1;
    tick(3);

    // Reset values
    checkOutput("rst_valid", {31'h0, valid}, 32'h0);
    checkOutput("rst_data", {24'h0, data}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_frame_err", {31'h0, frameErr}, 32'h0);
    checkOutput("rst_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("rst_drop_cnt", {16'h0, dropCnt}, 32'h0);
    rstN = 1'b1;
    tick(5);

    // Single byte
    $display("[TB] single byte");
    applyStimulus(8'h55, 16, 0, 1'b1);
    tick(20);
    checkOutput("single_xfers", xferCount, 1);
    checkOutput("single_frame_err", frameErrCount, 0);
    checkOutput("single_queue", sbQueue.size(), 0);

    // Back-to-back frames with no idle gap
    $display("[TB] back-to-back");
    applyStimulus(8'h41, 16, 0, 1'b1);
    applyStimulus(8'h0A, 16, 0, 1'b1);
    tick(20);
    checkOutput("b2b_xfers", xferCount, 3);
    checkOutput("b2b_queue", sbQueue.size(), 0);

    // Glitch rejection: 3-cycle low pulse
    $display("[TB] glitch");
    xferBefore = xferCount;
    rxLine = 1'b0;
    tick(3);
    checkOutput("glitch_busy_high", {31'h0, busy}, 32'h1);
    rxLine = 1'b1;
    tick(11);
    checkOutput("glitch_busy_low", {31'h0, busy}, 32'h0);
    tick(20);
    checkOutput("glitch_xfers", xferCount, xferBefore);
    checkOutput("glitch_frame_err", frameErrCount, 0);

    // Framing error with a 40-cycle low stop bit, then a good frame
    $display("[TB] framing error");
    applyBits(8'hA5, 0, 8, 16);
    rxLine = 1'b0;
    tick(40);
    checkOutput("break_busy", {31'h0, busy}, 32'h1);
    rxLine = 1'b1;
    tick(4);
    checkOutput("break_exit_busy", {31'h0, busy}, 32'h0);
    checkOutput("ferr_pulses", frameErrCount, 1);
    checkOutput("ferr_xfers", xferCount, xferBefore);
    tick(16);
    applyStimulus(8'h3C, 16, 0, 1'b1);
    tick(20);
    checkOutput("after_break_xfers", xferCount, xferBefore + 1);

    // Divisor below 4 is clamped to 4
    $display("[TB] divisor clamp");
    baudDiv = 16'd2;
    applyStimulus(8'hB7, 4, 0, 1'b1);
    tick(10);
    checkOutput("clamp_xfers", xferCount, xferBefore + 2);
    baudDiv = 16'd16;

    // Overflow and drain
    $display("[TB] overflow");
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'(i), 16, 0, i < 8);
    end
    tick(10);
    checkOutput("ovf_pulses", overflowCount, 1);
    checkOutput("ovf_drop_cnt", {16'h0, dropCnt}, 32'h1);
    checkOutput("ovf_valid", {31'h0, valid}, 32'h1);
    checkOutput("ovf_head", {24'h0, data}, 32'h0);
    ready = 1'b1;
    for (int i = 0; i < 50 && valid; i++) tick(1);
    checkOutput("drain_valid", {31'h0, valid}, 32'h0);
    checkOutput("drain_queue", sbQueue.size(), 0);

    // Synchronous reset after data bit 3
    $display("[TB] reset mid-frame");
    xferBefore = xferCount;
    errBefore  = frameErrCount;
    applyBits(8'h96, 0, 4, 16);
    rstN   = 1'b0;
    rxLine = 1'b1;
    tick(1);
    checkOutput("mid_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("mid_rst_valid", {31'h0, valid}, 32'h0);
    checkOutput("mid_rst_drop_cnt", {16'h0, dropCnt}, 32'h0);
    rstN = 1'b1;
    tick(48);
    checkOutput("mid_rst_xfers", xferCount, xferBefore);
    checkOutput("mid_rst_frame_err", frameErrCount, errBefore);

    // Disable mid-frame, then a full frame after re-enabling
    $display("[TB] disable mid-frame");
    applyBits(8'h5A, 0, 3, 16);
    enable = 1'b0;
    tick(1);
    checkOutput("dis_busy", {31'h0, busy}, 32'h0);
    applyBits(8'h5A, 4, 9, 16);
    enable = 1'b1;
    tick(32);
    checkOutput("dis_xfers", xferCount, xferBefore);
    applyStimulus(8'hC3, 16, 0, 1'b1);
    tick(20);
    checkOutput("en_xfers", xferCount, xferBefore + 1);
    checkOutput("final_queue", sbQueue.size(), 0);
    checkOutput("spurious", spuriousCount, 0);
    checkOutput("final_frame_err", frameErrCount, errBefore);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
